// File: rtl/fir_l3_p2s.sv
// Parallel-to-serial converter for the L=3 FIR datapath: buffers 3-sample blocks
// in a small FIFO and replays them one sample per clock with valid/ready on both sides.
module fir_l3_p2s #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic [15:0]       out_idx
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    lane;
  logic [15:0]   idx;

  logic push;
  logic xfer;
  logic pop;

  // in_ready depends only on registered count, so a full FIFO never accepts in its pop cycle
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign out_lane  = lane;
  assign out_idx   = idx;

  assign push = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign pop  = xfer && (lane == LANE2);

  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr] <= in_data0;
      mem1[wr_ptr] <= in_data1;
      mem2[wr_ptr] <= in_data2;
    end
  end

  always_comb begin
    out_data = mem0[rd_ptr];
    case (lane)
      LANE1:   out_data = mem1[rd_ptr];
      LANE2:   out_data = mem2[rd_ptr];
      default: out_data = mem0[rd_ptr];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      lane   <= LANE0;
      idx    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (xfer) begin
        idx  <= idx + 16'd1;
        lane <= (lane == LANE2) ? LANE0 : lane + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_l3_p2s.sv
// Randomised and directed bench for fir_l3_p2s against a sample-queue reference model.
module tb_fir_l3_p2s;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data0, in_data1, in_data2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_lane;
  logic [15:0]       out_idx;

  fir_l3_p2s #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: source blocks waiting to be offered, and the samples buffered in the DUT
  logic [3*DATA_W-1:0] src_q [$];
  logic [DATA_W-1:0]   exp_q [$];
  logic [15:0]         exp_idx;
  int                  xfers;
  bit                  offer;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_block(input logic [DATA_W-1:0] a, b, c);
    src_q.push_back({a, b, c});
  endtask

  task automatic drive();
    in_valid = offer && (src_q.size() != 0);
    if (src_q.size() != 0) {in_data0, in_data1, in_data2} = src_q[0];
    else {in_data0, in_data1, in_data2} = '0;
  endtask

  // One clock: compare at negedge, then apply the transfer rules at posedge
  task automatic step();
    int blocks;
    bit exp_rdy, exp_vld, push, pop;
    logic [3*DATA_W-1:0] blk;
    @(negedge clk);
    blocks  = (exp_q.size() + 2) / 3;
    exp_rdy = (blocks < DEPTH);
    exp_vld = (exp_q.size() != 0);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_vld);
    if (exp_vld) begin
      check("out_data", out_data, exp_q[0]);
      check("out_lane", out_lane, (3 - exp_q.size() % 3) % 3);
      check("out_idx", out_idx, exp_idx);
      if (out_ready && xfers == 65535) check("wrap_hi", out_idx, 64'hFFFF);
      if (out_ready && xfers == 65536) check("wrap_zero", out_idx, 64'h0);
    end
    push = in_valid && exp_rdy;
    pop  = exp_vld && out_ready;
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      exp_idx++;
      xfers++;
    end
    if (push) begin
      blk = src_q.pop_front();
      exp_q.push_back(blk[3*DATA_W-1:2*DATA_W]);
      exp_q.push_back(blk[2*DATA_W-1:DATA_W]);
      exp_q.push_back(blk[DATA_W-1:0]);
    end
    #1;
    drive();
  endtask

  task automatic model_reset();
    exp_q.delete();
    src_q.delete();
    exp_idx = '0;
    xfers   = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    offer = 1'b0;
    drive();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_lane", out_lane, 0);
    check("rst_out_idx", out_idx, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; offer = 1'b0;
    model_reset();
    drive();
    #2;
    do_reset();

    // Impulse
    out_ready = 1'b1; offer = 1'b1;
    add_block(1, 0, 0);
    drive();
    repeat (6) step();

    // Streaming: 1..9 with no gaps
    add_block(1, 2, 3); add_block(4, 5, 6); add_block(7, 8, 9);
    drive();
    repeat (14) step();

    // Backpressure: only two blocks fit, third waits for the first pop
    out_ready = 1'b0;
    add_block(11, 12, 13); add_block(21, 22, 23); add_block(31, 32, 33);
    drive();
    repeat (5) step();
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    repeat (14) step();

    // Mid-block stall with sign-sensitive values
    add_block(-32'sd5, 32'sd32767, -32'sd32768);
    drive();
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();

    // Reset after the lane-1 transfer with a second block queued
    out_ready = 1'b0;
    add_block(41, 42, 43); add_block(51, 52, 53);
    drive();
    repeat (4) step();
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    #2;
    do_reset();
    out_ready = 1'b1; offer = 1'b1;
    add_block(9, 9, 9);
    drive();
    repeat (5) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 3) add_block($urandom, $urandom, $urandom);
      offer     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end

    // Counter wrap: 65537 transfers from reset
    do_reset();
    out_ready = 1'b1; offer = 1'b1;
    for (int i = 0; i < 66000 && xfers < 65537; i++) begin
      if (src_q.size() < 2) add_block($urandom, $urandom, $urandom);
      drive();
      step();
    end
    check("wrap_xfers_done", (xfers >= 65537), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_l3_p2s.md
# fir_l3_p2s

Parallel-to-serial output converter for the L=3 parallel FIR datapath. It accepts one 3-sample output block per handshake and replays it as a one-sample-per-clock stream, y(3k), y(3k+1), y(3k+2), with valid/ready flow control on both sides. A small block FIFO decouples the two sides. It sits directly behind the parallel FIR core and feeds sample-rate consumers: loggers, DAC interfaces and checkers.

## Interface
- DATA_W, 32, width of each output sample (signed, two's complement, passed through unmodified)
- DEPTH, 2, block FIFO depth in 3-sample blocks; power of two, at least 2
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- in_valid  input  1  input block present
- in_ready  output  1  block FIFO can accept a block
- in_data0  input  DATA_W  block sample y(3k), emitted first
- in_data1  input  DATA_W  block sample y(3k+1)
- in_data2  input  DATA_W  block sample y(3k+2), emitted last
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  downstream accepts the sample
- out_data  output  DATA_W  current serial sample
- out_lane  output  2  lane index of out_data (0, 1, 2)
- out_idx  output  16  running count of output transfers, modulo 65536

## Operation
- Input transfer happens when in_valid && in_ready. The block {in_data0, in_data1, in_data2} is written at wr_ptr, then wr_ptr increments and count increments.
- Output transfer happens when out_valid && out_ready. On a transfer:
  - lane advances 0→1→2→0.
  - out_idx increments, wrapping 65535→0.
  - On the lane-2 transfer, the head block is popped: rd_ptr increments and count decrements.
- out_valid = (count != 0).
- out_data = the head block's sample selected by lane. Combinational mux from FIFO storage.
- out_lane = lane.
- in_ready = (count < DEPTH). There is no same-cycle pass-through: when the FIFO is full, in_ready stays 0 even in a cycle that pops.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Data is never altered, truncated or sign-adjusted.
- in_valid asserted while in_ready=0 is legal. The block is not taken and the source holds it.
- out_ready deasserted mid-block: lane, out_data and out_idx hold until a transfer occurs.

## Timing
- Reset (reset=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, lane=0, out_idx=0.
  - Outputs: out_valid=0, in_ready=1, out_lane=0.
  - out_data is don't-care while out_valid=0. FIFO storage is not reset.
- Reset asserted mid-block discards every buffered sample. The first transfer after release is lane 0 of the next accepted block.
- Latency: a block accepted at edge N gives out_valid=1 and lane-0 data after edge N, provided the FIFO was empty.
- The last sample of the block (lane 2) is presented 2 cycles later when out_ready is held at 1.
- Throughput: 1 sample/clk with out_ready=1. Sustained input rate is 1 block per 3 clocks.
- With DEPTH=2 and out_ready=1, in_valid=1 continuously never causes an output bubble.
- State per head block, driven by lane: LANE0 → LANE1 → LANE2 → (pop) → LANE0. Each transition happens on an output transfer only.

## Test plan
- Impulse: reset low for 2 cycles, then one block (1,0,0) with out_ready=1.
  - Required: out_data 1,0,0 on three consecutive cycles with out_lane 0,1,2 and out_idx 0,1,2.
  - Then out_valid=0.
- Streaming: blocks (1,2,3), (4,5,6), (7,8,9) offered continuously with out_ready=1.
  - Required: output 1..9 on 9 consecutive cycles with no gaps.
  - in_ready pattern stays consistent with count ≤ DEPTH.
- Backpressure: out_ready=0, offer 3 blocks.
  - Required: exactly 2 are accepted, then in_ready=0.
  - After raising out_ready, output sequence is blocks 1 and 2 in order.
  - The third block is accepted only after the first pop, never in the pop cycle.
- Mid-block stall: toggle out_ready every cycle during block (-5, 32767, -32768).
  - Required: each value appears exactly once, held across stall cycles, sign preserved.
- Reset mid-operation: assert reset after the lane-1 transfer with one block still queued.
  - Required: out_valid=0 and in_ready=1 immediately (asynchronous).
  - After release, a new block (9,9,9) outputs starting at lane 0 with out_idx=0.
- Counter wrap: 65537 output transfers.
  - Required: out_idx reads 65535 on transfer 65536 and 0 on transfer 65537.
